// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: port ids, read-sequencer states
// and the request record that is muxed onto the memory bus as one unit.
package common;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_DMA  = 1'b1
  } arb_port_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  localparam int NUM_PORTS = 2;

  // One-hot preference vector for a port id (bit 0 = core, bit 1 = dma).
  function automatic logic [NUM_PORTS-1:0] port_onehot(arb_port_e p);
    return (p == ARB_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// master = arbiter view, slave = requester/memory (environment) view.
interface dmem_arbiter_if;

  logic        core_req,    dma_req;
  logic        core_we,     dma_we;
  logic [31:0] core_addr,   dma_addr;
  logic [31:0] core_wdata,  dma_wdata;
  logic [3:0]  core_wstrb,  dma_wstrb;
  logic        core_gnt,    dma_gnt;
  logic        core_rvalid, dma_rvalid;
  logic [31:0] core_rdata,  dma_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  core_req, core_we, core_addr, core_wdata, core_wstrb,
    input  dma_req,  dma_we,  dma_addr,  dma_wdata,  dma_wstrb,
    input  mem_rdata,
    output core_gnt, dma_gnt, core_rvalid, dma_rvalid, core_rdata, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output core_req, core_we, core_addr, core_wdata, core_wstrb,
    output dma_req,  dma_we,  dma_addr,  dma_wdata,  dma_wstrb,
    output mem_rdata,
    input  core_gnt, dma_gnt, core_rvalid, dma_rvalid, core_rdata, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/dmem_arbiter_pick2.sv
// Combinational two-input grant selector. A lone requester always wins;
// on contention the preferred port wins (prefer[1] set -> dma, else core).
module arb_pick2 (
  input  logic [1:0] req,
  input  logic [1:0] prefer,
  output logic [1:0] gnt
);

  // One-hot grant; contention resolved by the preference vector.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prefer[1] ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and read sequencer in front of the single-ported data
// memory. Fixed core priority with dma aging by default; strict alternation
// when DMEM_ARB_RR_EN is defined.
module dmem_arbiter
  import common::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.master bus
);

  logic [1:0] req, prefer, pick, gnt;
  dmem_req_t  core_r, dma_r, sel_r;
  logic       rd_grant;
  arb_port_e  gnt_port;

  arb_port_e  last_gnt_q, last_gnt_d;
  rd_state_e  rd_state_q, rd_state_d;
  arb_port_e  rd_owner_q, rd_owner_d;

  assign req = {bus.dma_req, bus.core_req};

`ifdef DMEM_ARB_RR_EN
  // On contention, hand the memory to whoever did not get it last.
  assign prefer = (last_gnt_q == ARB_CORE) ? port_onehot(ARB_DMA) : port_onehot(ARB_CORE);
`else
  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           aged;
  logic           unused_last_gnt;

  // last_gnt is kept for observability only; it never steers this build.
  assign unused_last_gnt = last_gnt_q;

  assign aged   = (wait_cnt_q == WCW'(MAX_WAIT));
  assign prefer = aged ? port_onehot(ARB_DMA) : port_onehot(ARB_CORE);

  // Count cycles the dma port loses while requesting; saturate at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (bus.dma_req && !gnt[1]) wait_cnt_d = aged ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  // Aging counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`endif

  arb_pick2 u_pick (
    .req    (req),
    .prefer (prefer),
    .gnt    (pick)
  );

  // No access may be issued while reset is held.
  assign gnt      = pick & {2{reset_n}};
  assign gnt_port = gnt[1] ? ARB_DMA : ARB_CORE;

  assign core_r = '{we: bus.core_we, addr: bus.core_addr, wdata: bus.core_wdata, wstrb: bus.core_wstrb};
  assign dma_r  = '{we: bus.dma_we,  addr: bus.dma_addr,  wdata: bus.dma_wdata,  wstrb: bus.dma_wstrb};
  assign sel_r  = gnt[1] ? dma_r : core_r;

  assign bus.core_gnt  = gnt[0];
  assign bus.dma_gnt   = gnt[1];
  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = bus.mem_en & sel_r.we;
  assign bus.mem_wstrb = bus.mem_we ? sel_r.wstrb : 4'h0;
  assign bus.mem_addr  = sel_r.addr;
  assign bus.mem_wdata = sel_r.wdata;

  assign rd_grant = bus.mem_en & ~sel_r.we;

  // Remember the most recent winner.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (|gnt) last_gnt_d = gnt_port;
  end

  // Read sequencer: one-cycle response slot, re-armed by each read grant so
  // back-to-back reads pipeline at one per cycle.
  always_comb begin
    rd_state_d     = RD_IDLE;
    rd_owner_d     = rd_owner_q;
    bus.core_rvalid = 1'b0;
    bus.dma_rvalid  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_grant) begin
          rd_state_d = RD_RESP;
          rd_owner_d = gnt_port;
        end
      end
      RD_RESP: begin
        bus.core_rvalid = (rd_owner_q == ARB_CORE);
        bus.dma_rvalid  = (rd_owner_q == ARB_DMA);
        if (rd_grant) begin
          rd_state_d = RD_RESP;
          rd_owner_d = gnt_port;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign bus.core_rdata = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;

  // Arbitration history and read-sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= ARB_DMA;
      rd_state_q <= RD_IDLE;
      rd_owner_q <= ARB_CORE;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule
